gf180mcu_fd_sc_mcu7t5v0__buf_fifo: RTL and testbench



---
 rtl/gf180mcu_fd_sc_mcu7t5v0__buf_fifo.sv | 63 ++++++
 tb/tb_gf180mcu_fd_sc_mcu7t5v0__buf_fifo.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__buf_fifo.sv
// Elastic buffer: WIDTH-bit, DEPTH-entry FIFO with valid/ready on both sides.
// All outputs derive from registered state only; no input reaches an output combinationally.
module gf180mcu_fd_sc_mcu7t5v0__buf_fifo #(
   parameter  int WIDTH = 1,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             CLK,
   input  logic             RN,
   input  logic [WIDTH-1:0] I,
   input  logic             I_VALID,
   output logic             I_READY,
   output logic [WIDTH-1:0] Z,
   output logic             Z_VALID,
   input  logic             Z_READY,
   output logic [AW:0]      COUNT
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count, count_nxt;
   logic             i_ready, z_valid;
   logic             push, pop;

   assign push = I_VALID & i_ready;
   assign pop  = z_valid & Z_READY;

   always_comb begin
      count_nxt = count;
      if (push && !pop)
         count_nxt = count + (AW+1)'(1);
      else if (pop && !push)
         count_nxt = count - (AW+1)'(1);
   end

   // Flags are registered from the next count so they are ready at the edge they describe.
   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         z_valid <= 1'b0;
         i_ready <= 1'b1;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count   <= count_nxt;
         z_valid <= (count_nxt != '0);
         i_ready <= (count_nxt != (AW+1)'(DEPTH));
      end
   end

   // Storage is deliberately left out of reset; Z is gated by z_valid instead.
   always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr] <= I;
   end

   assign Z       = z_valid ? mem[rd_ptr] : '0;
   assign Z_VALID = z_valid;
   assign I_READY = i_ready;
   assign COUNT   = count;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__buf_fifo.sv
// Bench for the elastic buffer: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic with resets.
module tb_gf180mcu_fd_sc_mcu7t5v0__buf_fifo;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int AW    = $clog2(DEPTH);

   logic             CLK = 1'b0;
   logic             RN = 1'b0;
   logic [WIDTH-1:0] I = '0;
   logic             I_VALID = 1'b0;
   logic             I_READY;
   logic [WIDTH-1:0] Z;
   logic             Z_VALID;
   logic             Z_READY = 1'b0;
   logic [AW:0]      COUNT;

   int checks = 0;
   int failures = 0;

   gf180mcu_fd_sc_mcu7t5v0__buf_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .CLK(CLK), .RN(RN), .I(I), .I_VALID(I_VALID), .I_READY(I_READY),
      .Z(Z), .Z_VALID(Z_VALID), .Z_READY(Z_READY), .COUNT(COUNT)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: a plain queue; the buffer is whatever the queue holds.
   logic [WIDTH-1:0] q[$];

   always @(posedge CLK or negedge RN) begin
      if (!RN) begin
         q.delete();
      end else begin
         bit do_push, do_pop;
         do_push = I_VALID && (q.size() < DEPTH);
         do_pop  = Z_READY && (q.size() > 0);
         if (do_pop)  void'(q.pop_front());
         if (do_push) q.push_back(I);
      end
   end

   always @(negedge CLK) begin
      chk("model_count",   32'(COUNT),   32'(q.size()));
      chk("model_z_valid", 32'(Z_VALID), 32'(q.size() != 0));
      chk("model_i_ready", 32'(I_READY), 32'(q.size() != DEPTH));
      chk("model_z",       32'(Z),       (q.size() != 0) ? 32'(q[0]) : 32'h0);
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic push_word(input logic [WIDTH-1:0] d);
      I = d; I_VALID = 1'b1;
      step();
      I_VALID = 1'b0;
   endtask

   initial begin
      logic [WIDTH-1:0] fill_exp [4];
      logic [WIDTH-1:0] wrap_exp [4];

      // Reset held with random inputs.
      for (int k = 0; k < 4; k++) begin
         I = WIDTH'($urandom); I_VALID = 1'($urandom); Z_READY = 1'($urandom);
         step();
      end
      chk("rst_z", 32'(Z), 32'h00);
      chk("rst_z_valid", 32'(Z_VALID), 32'h0);
      chk("rst_i_ready", 32'(I_READY), 32'h1);
      chk("rst_count", 32'(COUNT), 32'h0);
      I_VALID = 1'b0; Z_READY = 1'b0;
      RN = 1'b1;
      step();

      // Single pass with a held output.
      push_word(8'hA5);
      chk("single_z", 32'(Z), 32'hA5);
      chk("single_z_valid", 32'(Z_VALID), 32'h1);
      chk("single_count", 32'(COUNT), 32'h1);
      for (int k = 0; k < 5; k++) begin
         step();
         chk("single_hold_z", 32'(Z), 32'hA5);
      end
      Z_READY = 1'b1;
      step();
      Z_READY = 1'b0;
      chk("single_pop_z_valid", 32'(Z_VALID), 32'h0);
      chk("single_pop_z", 32'(Z), 32'h00);

      // Fill to full, reject an extra word, drain in order.
      fill_exp = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int k = 0; k < 4; k++) push_word(fill_exp[k]);
      chk("full_count", 32'(COUNT), 32'h4);
      chk("full_i_ready", 32'(I_READY), 32'h0);
      push_word(8'h55);
      chk("full_reject_count", 32'(COUNT), 32'h4);
      Z_READY = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk("drain_z", 32'(Z), 32'(fill_exp[k]));
         step();
      end
      Z_READY = 1'b0;
      chk("drain_empty_count", 32'(COUNT), 32'h0);
      chk("drain_empty_z_valid", 32'(Z_VALID), 32'h0);

      // Streaming 20 words: pointers wrap five times, count stays at one.
      I_VALID = 1'b1; Z_READY = 1'b1;
      for (int k = 0; k < 20; k++) begin
         I = WIDTH'(k);
         step();
         chk("stream_count", 32'(COUNT), 32'h1);
         chk("stream_z", 32'(Z), 32'(k));
      end
      I_VALID = 1'b0;
      step();
      Z_READY = 1'b0;
      chk("stream_end_count", 32'(COUNT), 32'h0);

      // Full with a simultaneous pop: the push must wait one cycle.
      for (int k = 1; k <= 4; k++) push_word(WIDTH'(k));
      I = 8'h66; I_VALID = 1'b1; Z_READY = 1'b1;
      step();
      Z_READY = 1'b0;
      chk("fullpop_count", 32'(COUNT), 32'h3);
      chk("fullpop_i_ready", 32'(I_READY), 32'h1);
      step();
      I_VALID = 1'b0;
      chk("fullpop_push_count", 32'(COUNT), 32'h4);
      wrap_exp = '{8'h02, 8'h03, 8'h04, 8'h66};
      Z_READY = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk("fullpop_drain_z", 32'(Z), 32'(wrap_exp[k]));
         step();
      end
      Z_READY = 1'b0;

      // Asynchronous reset mid-operation.
      for (int k = 0; k < 3; k++) push_word(8'hC0 + WIDTH'(k));
      chk("midrst_pre_count", 32'(COUNT), 32'h3);
      #2 RN = 1'b0;
      #1;
      chk("midrst_async_count", 32'(COUNT), 32'h0);
      chk("midrst_async_z_valid", 32'(Z_VALID), 32'h0);
      chk("midrst_async_z", 32'(Z), 32'h00);
      step();
      RN = 1'b1;
      push_word(8'h77);
      chk("midrst_z", 32'(Z), 32'h77);
      chk("midrst_count", 32'(COUNT), 32'h1);
      Z_READY = 1'b1;
      step();
      Z_READY = 1'b0;
      chk("midrst_alone_count", 32'(COUNT), 32'h0);

      // Randomized traffic with occasional resets; the model compare does the checking.
      for (int k = 0; k < 3000; k++) begin
         I       = WIDTH'($urandom);
         I_VALID = ($urandom_range(0, 3) != 0);
         Z_READY = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 199) == 0) RN = 1'b0;
         else RN = 1'b1;
         step();
      end
      RN = 1'b1; I_VALID = 1'b0; Z_READY = 1'b0;
      step();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
